// File: rtl/blake2_g_inv_if.sv
// Handshake and data bundle for the iterative inverse BLAKE2 G block.
// master: the side supplying G outputs and taking recovered inputs.
// slave: the inverse-G block itself.
interface blake2_g_inv_if #(
  parameter int W = 32
);
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] c_i;
  logic [W-1:0] d_i;
  logic [W-1:0] x_i;
  logic [W-1:0] y_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] a_o;
  logic [W-1:0] b_o;
  logic [W-1:0] c_o;
  logic [W-1:0] d_o;

  modport master (
    output valid_i, a_i, b_i, c_i, d_i, x_i, y_i, ready_i,
    input  ready_o, valid_o, a_o, b_o, c_o, d_o
  );

  modport slave (
    input  valid_i, a_i, b_i, c_i, d_i, x_i, y_i, ready_i,
    output ready_o, valid_o, a_o, b_o, c_o, d_o
  );
endinterface

// File: rtl/blake2_g_inv.sv
// Iterative inverse of the BLAKE2 G mixing function: unwinds one ARX step
// per BUSY cycle and presents the recovered G inputs in DONE.
// Build option: BLAKE2_G_INV_DUAL_STEP_EN performs two steps per BUSY cycle.
//
// state | meaning
// IDLE  | ready_o high, waiting for valid_i
// BUSY  | applying inverse step(s) selected by step
// DONE  | valid_o high, result held until ready_i
module blake2_g_inv #(
  parameter int W  = 32,
  parameter int R1 = 16,
  parameter int R2 = 12,
  parameter int R3 = 8,
  parameter int R4 = 7
) (
  input  logic             clk,
  input  logic             nreset,
  blake2_g_inv_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
  } words_t;

  state_t       state, state_nxt;
  logic [2:0]   step, step_nxt;
  words_t       w, w_nxt;
  logic [W-1:0] x, x_nxt;
  logic [W-1:0] y, y_nxt;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
    return (v << r) | (v >> (W - r));
  endfunction

  // Steps undo the forward G in reverse order: 0..3 undo its second half
  // (message word y), 4..7 undo its first half (message word x).
  function automatic words_t inv_step(input logic [2:0] s, input words_t v,
                                      input logic [W-1:0] mx, input logic [W-1:0] my);
    words_t r;
    r = v;
    case (s)
      3'd0:    r.b = rotl(v.b, R4) ^ v.c;
      3'd1:    r.c = v.c - v.d;
      3'd2:    r.d = rotl(v.d, R3) ^ v.a;
      3'd3:    r.a = v.a - v.b - my;
      3'd4:    r.b = rotl(v.b, R2) ^ v.c;
      3'd5:    r.c = v.c - v.d;
      3'd6:    r.d = rotl(v.d, R1) ^ v.a;
      default: r.a = v.a - v.b - mx;
    endcase
    return r;
  endfunction

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    w_nxt     = w;
    x_nxt     = x;
    y_nxt     = y;
    case (state)
      IDLE: begin
        if (bus.valid_i) begin
          w_nxt     = '{a: bus.a_i, b: bus.b_i, c: bus.c_i, d: bus.d_i};
          x_nxt     = bus.x_i;
          y_nxt     = bus.y_i;
          step_nxt  = 3'd0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
`ifdef BLAKE2_G_INV_DUAL_STEP_EN
        w_nxt    = inv_step(step + 3'd1, inv_step(step, w, x, y), x, y);
        step_nxt = step + 3'd2;
        if (step == 3'd6) begin
          step_nxt  = 3'd0;
          state_nxt = DONE;
        end
`else
        w_nxt    = inv_step(step, w, x, y);
        step_nxt = step + 3'd1;
        if (step == 3'd7) begin
          step_nxt  = 3'd0;
          state_nxt = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.ready_i) begin
          step_nxt  = 3'd0;
          state_nxt = IDLE;
        end
      end
      default: begin
        step_nxt  = 3'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and working registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      step  <= 3'd0;
      w     <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      w     <= w_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
    end
  end

  // Working registers feed the outputs directly; they only move in BUSY,
  // so the result is stable for as long as DONE lasts.
  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = (state == DONE);
  assign bus.a_o     = w.a;
  assign bus.b_o     = w.b;
  assign bus.c_o     = w.c;
  assign bus.d_o     = w.d;

endmodule

// File: tb/tb_blake2_g_inv.sv
// Self-checking bench for blake2_g_inv: a forward-G model produces the
// inputs, the original words go to a scoreboard and are compared against
// the recovered outputs. Covers W=32 (BLAKE2s) and W=64 (BLAKE2b).
module tb_blake2_g_inv;

`ifdef BLAKE2_G_INV_DUAL_STEP_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 9;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } w32_t;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] d;
  } w64_t;

  logic clk;
  logic nreset;
  int   vectors = 0;
  int   miscompares = 0;
  w32_t sb32[$];
  w64_t sb64[$];

  blake2_g_inv_if #(.W(32)) bus32 ();
  blake2_g_inv_if #(.W(64)) bus64 ();

  blake2_g_inv #(.W(32), .R1(16), .R2(12), .R3(8), .R4(7)) dut32 (
    .clk(clk), .nreset(nreset), .bus(bus32)
  );

  blake2_g_inv #(.W(64), .R1(32), .R2(24), .R3(16), .R4(63)) dut64 (
    .clk(clk), .nreset(nreset), .bus(bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ror32(input logic [31:0] v, input int r);
    return (v >> r) | (v << (32 - r));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  function automatic w32_t g32(input w32_t v, input logic [31:0] x, input logic [31:0] y);
    w32_t r;
    r = v;
    r.a = r.a + r.b + x; r.d = ror32(r.d ^ r.a, 16);
    r.c = r.c + r.d;     r.b = ror32(r.b ^ r.c, 12);
    r.a = r.a + r.b + y; r.d = ror32(r.d ^ r.a, 8);
    r.c = r.c + r.d;     r.b = ror32(r.b ^ r.c, 7);
    return r;
  endfunction

  function automatic w64_t g64(input w64_t v, input logic [63:0] x, input logic [63:0] y);
    w64_t r;
    r = v;
    r.a = r.a + r.b + x; r.d = ror64(r.d ^ r.a, 32);
    r.c = r.c + r.d;     r.b = ror64(r.b ^ r.c, 24);
    r.a = r.a + r.b + y; r.d = ror64(r.d ^ r.a, 16);
    r.c = r.c + r.d;     r.b = ror64(r.b ^ r.c, 63);
    return r;
  endfunction

  function automatic w32_t rnd32();
    w32_t r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  function automatic w64_t rnd64();
    w64_t r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  function automatic w32_t out32();
    w32_t r;
    r = {bus32.a_o, bus32.b_o, bus32.c_o, bus32.d_o};
    return r;
  endfunction

  // Waits for ready_o, presents one word set, returns just after the accept edge.
  task automatic send32(input w32_t v, input logic [31:0] x, input logic [31:0] y);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus32.ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus32.ready_o) begin
      vectors++; miscompares++;
      $display("FAIL send32_ready got ready_o=%b exp 1", bus32.ready_o);
    end
    {bus32.a_i, bus32.b_i, bus32.c_i, bus32.d_i} = v;
    bus32.x_i = x;
    bus32.y_i = y;
    bus32.valid_i = 1'b1;
    @(posedge clk);
    #1 bus32.valid_i = 1'b0;
  endtask

  // Called right after the accept edge; lat counts cycles until valid_o is seen.
  task automatic recv32(output w32_t got, output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (bus32.valid_o) break;
      lat++;
    end
    if (!bus32.valid_o) begin
      vectors++; miscompares++;
      $display("FAIL recv32_valid got valid_o=%b exp 1", bus32.valid_o);
    end
    got = out32();
    bus32.ready_i = 1'b1;
    @(posedge clk);
    #1 bus32.ready_i = 1'b0;
  endtask

  task automatic send64(input w64_t v, input logic [63:0] x, input logic [63:0] y);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus64.ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus64.ready_o) begin
      vectors++; miscompares++;
      $display("FAIL send64_ready got ready_o=%b exp 1", bus64.ready_o);
    end
    {bus64.a_i, bus64.b_i, bus64.c_i, bus64.d_i} = v;
    bus64.x_i = x;
    bus64.y_i = y;
    bus64.valid_i = 1'b1;
    @(posedge clk);
    #1 bus64.valid_i = 1'b0;
  endtask

  task automatic recv64(output w64_t got);
    int t;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      if (bus64.valid_o) break;
      t++;
    end
    if (!bus64.valid_o) begin
      vectors++; miscompares++;
      $display("FAIL recv64_valid got valid_o=%b exp 1", bus64.valid_o);
    end
    got = {bus64.a_o, bus64.b_o, bus64.c_o, bus64.d_o};
    bus64.ready_i = 1'b1;
    @(posedge clk);
    #1 bus64.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({bus32.ready_o, bus32.valid_o, out32()} !== {1'b1, 1'b0, 128'h0}) begin
      miscompares++;
      $display("FAIL reset32 got rdy=%b vld=%b out=%h exp rdy=1 vld=0 out=0",
               bus32.ready_o, bus32.valid_o, out32());
    end
    vectors++;
    if ({bus64.ready_o, bus64.valid_o, bus64.a_o, bus64.b_o, bus64.c_o, bus64.d_o}
        !== {1'b1, 1'b0, 256'h0}) begin
      miscompares++;
      $display("FAIL reset64 got rdy=%b vld=%b exp rdy=1 vld=0 out=0",
               bus64.ready_o, bus64.valid_o);
    end
  endtask

  task automatic test_zero();
    w32_t got, exp;
    int   lat;
    sb32.push_back('0);
    send32('0, 32'h0, 32'h0);
    recv32(got, lat);
    exp = sb32.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL zero got=%h exp=%h", got, exp);
    end
    // valid_o is seen in the cycle that ends at edge accept+LAT
    vectors++;
    if (lat !== LAT - 1) begin
      miscompares++;
      $display("FAIL latency got=%0d exp=%0d", lat + 1, LAT);
    end
  endtask

  task automatic test_known();
    w32_t got, exp;
    int   lat;
    sb32.push_back({32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0001_0001});
    send32({32'h1, 32'h0, 32'h0, 32'h0}, 32'h0, 32'h0);
    recv32(got, lat);
    exp = sb32.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL known got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_roundtrip32();
    w32_t orig, got, exp;
    logic [31:0] x, y;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      orig = rnd32();
      x = $urandom;
      y = $urandom;
      sb32.push_back(orig);
      send32(g32(orig, x, y), x, y);
      recv32(got, lat);
      exp = sb32.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL roundtrip32[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_roundtrip64();
    w64_t orig, got, exp;
    logic [63:0] x, y;
    for (int i = 0; i < 1000; i++) begin
      orig = rnd64();
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      sb64.push_back(orig);
      send64(g64(orig, x, y), x, y);
      recv64(got);
      exp = sb64.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL roundtrip64[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_hold();
    w32_t orig, held, exp;
    logic [31:0] x, y;
    int t;
    orig = rnd32();
    x = $urandom;
    y = $urandom;
    sb32.push_back(orig);
    send32(g32(orig, x, y), x, y);
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      if (bus32.valid_o) break;
      t++;
    end
    held = out32();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({bus32.valid_o, bus32.ready_o, out32()} !== {1'b1, 1'b0, held}) begin
        miscompares++;
        $display("FAIL hold[%0d] got vld=%b rdy=%b out=%h exp vld=1 rdy=0 out=%h",
                 i, bus32.valid_o, bus32.ready_o, out32(), held);
      end
      {bus32.a_i, bus32.b_i, bus32.c_i, bus32.d_i} = rnd32();
      bus32.valid_i = i[0];
    end
    @(negedge clk);
    bus32.valid_i = 1'b0;
    exp = sb32.pop_front();
    vectors++;
    if (out32() !== exp) begin
      miscompares++;
      $display("FAIL hold_result got=%h exp=%h", out32(), exp);
    end
    bus32.ready_i = 1'b1;
    @(posedge clk);
    #1 bus32.ready_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus32.ready_o, bus32.valid_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL hold_release got rdy=%b vld=%b exp rdy=1 vld=0",
               bus32.ready_o, bus32.valid_o);
    end
  endtask

  task automatic test_reset_mid();
    w32_t orig, got, exp;
    logic [31:0] x, y;
    int lat;
    send32(rnd32(), $urandom, $urandom);
    repeat (4) @(posedge clk);
    #1 nreset = 1'b0;
    @(posedge clk);
    #1 nreset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus32.valid_o, bus32.ready_o, out32()} !== {1'b0, 1'b1, 128'h0}) begin
      miscompares++;
      $display("FAIL reset_mid got vld=%b rdy=%b out=%h exp vld=0 rdy=1 out=0",
               bus32.valid_o, bus32.ready_o, out32());
    end
    orig = rnd32();
    x = $urandom;
    y = $urandom;
    sb32.push_back(orig);
    send32(g32(orig, x, y), x, y);
    recv32(got, lat);
    exp = sb32.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_mid_after got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    w32_t orig[N];
    logic [31:0] xs[N], ys[N];
    w32_t exp;
    int k, rcv, cyc, last_acc;
    for (int i = 0; i < N; i++) begin
      orig[i] = rnd32();
      xs[i] = $urandom;
      ys[i] = $urandom;
    end
    k = 0; rcv = 0; cyc = 0; last_acc = -1;
    bus32.ready_i = 1'b1;
    while (rcv < N && cyc < N * (LAT + 1) + 50) begin
      @(negedge clk);
      cyc++;
      if (bus32.valid_o) begin
        exp = sb32.pop_front();
        vectors++;
        if (out32() !== exp) begin
          miscompares++;
          $display("FAIL b2b_data[%0d] got=%h exp=%h", rcv, out32(), exp);
        end
        rcv++;
      end
      if (bus32.ready_o) begin
        if (k < N) begin
          {bus32.a_i, bus32.b_i, bus32.c_i, bus32.d_i} = g32(orig[k], xs[k], ys[k]);
          bus32.x_i = xs[k];
          bus32.y_i = ys[k];
          bus32.valid_i = 1'b1;
          sb32.push_back(orig[k]);
          if (last_acc >= 0) begin
            vectors++;
            if (cyc - last_acc !== LAT + 1) begin
              miscompares++;
              $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", k, cyc - last_acc, LAT + 1);
            end
          end
          last_acc = cyc;
          k++;
        end else begin
          bus32.valid_i = 1'b0;
        end
      end
    end
    bus32.valid_i = 1'b0;
    bus32.ready_i = 1'b0;
    vectors++;
    if (rcv !== N || sb32.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_count got=%0d pending=%0d exp=%0d pending=0", rcv, sb32.size(), N);
    end
  endtask

  initial begin
    nreset = 1'b0;
    bus32.valid_i = 1'b0; bus32.ready_i = 1'b0;
    bus32.a_i = '0; bus32.b_i = '0; bus32.c_i = '0; bus32.d_i = '0;
    bus32.x_i = '0; bus32.y_i = '0;
    bus64.valid_i = 1'b0; bus64.ready_i = 1'b0;
    bus64.a_i = '0; bus64.b_i = '0; bus64.c_i = '0; bus64.d_i = '0;
    bus64.x_i = '0; bus64.y_i = '0;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    test_reset();
    test_zero();
    test_known();
    test_roundtrip32();
    test_roundtrip64();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
